// File: rtl/classifier_seq_ctrl.sv
// Valid/ready sequencer around the combinational classifier core: holds each sample on the core
// input for SETTLE_CYCLES, captures the class, then presents it downstream. Optional CLS_HIST_EN adds per-class histogram.
module classifier_seq_ctrl #(
    parameter int NUM_INP       = 5,
    parameter int WIDTH_A       = 8,
    parameter int OUTWIDTH      = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [NUM_INP*WIDTH_A-1:0]   s_data,
    output logic [NUM_INP*WIDTH_A-1:0]   cls_inp,
    input  logic [OUTWIDTH-1:0]          cls_out,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [OUTWIDTH-1:0]          m_class,
    output logic                         busy,
    output logic [CNT_W-1:0]             sample_cnt
`ifdef CLS_HIST_EN
    ,
    input  logic                         hist_clr,
    output logic [(2**OUTWIDTH)*CNT_W-1:0] hist_cnt
`endif
);

    localparam int DW   = NUM_INP * WIDTH_A;
    localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int NCLS = 2 ** OUTWIDTH;

    generate
        if (SETTLE_CYCLES < 1) begin : g_settle_chk
            $error("classifier_seq_ctrl: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        cls_inp_q, cls_inp_d;
    logic [OUTWIDTH-1:0]  m_class_q, m_class_d;
    logic                 m_valid_q, m_valid_d;
    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic                 out_hs_s;

    // Next-state and datapath decode for the three-state sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cls_inp_d    = cls_inp_q;
        m_class_d    = m_class_q;
        m_valid_d    = m_valid_q;
        sample_cnt_d = sample_cnt_q;
        s_ready      = 1'b0;
        busy         = 1'b0;
        out_hs_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    cls_inp_d = s_data;
                    cnt_d     = SW'(SETTLE_CYCLES - 1);
                    state_d   = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                // The core output is only trusted at the end of the window.
                if (cnt_q != {SW{1'b0}}) begin
                    cnt_d = cnt_q - SW'(1);
                end else begin
                    m_class_d = cls_out;
                    m_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                busy = 1'b1;
                if (m_valid_q && m_ready) begin
                    out_hs_s     = 1'b1;
                    m_valid_d    = 1'b0;
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {SW{1'b0}};
            cls_inp_q    <= {DW{1'b0}};
            m_class_q    <= {OUTWIDTH{1'b0}};
            m_valid_q    <= 1'b0;
            sample_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cls_inp_q    <= cls_inp_d;
            m_class_q    <= m_class_d;
            m_valid_q    <= m_valid_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign cls_inp    = cls_inp_q;
    assign m_class    = m_class_q;
    assign m_valid    = m_valid_q;
    assign sample_cnt = sample_cnt_q;

`ifdef CLS_HIST_EN
    logic [CNT_W-1:0] hist_q [NCLS];
    logic [CNT_W-1:0] hist_d [NCLS];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Histogram update: clear wins over a same-cycle handshake increment.
    always_comb begin
        for (int c = 0; c < NCLS; c++) begin
            if (hist_clr) begin
                hist_d[c] = {CNT_W{1'b0}};
            end else if (out_hs_s && (m_class_q == OUTWIDTH'(c))) begin
                hist_d[c] = sat_inc(hist_q[c]);
            end else begin
                hist_d[c] = hist_q[c];
            end
        end
    end

    // Histogram counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCLS; c++) begin
                hist_q[c] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < NCLS; c++) begin
                hist_q[c] <= hist_d[c];
            end
        end
    end

    // Flatten counters onto the output bus, class c at [c*CNT_W +: CNT_W].
    always_comb begin
        hist_cnt = {((2**OUTWIDTH)*CNT_W){1'b0}};
        for (int c = 0; c < NCLS; c++) begin
            hist_cnt[c*CNT_W +: CNT_W] = hist_q[c];
        end
    end
`else
    logic unused_hs_s;
    assign unused_hs_s = out_hs_s;
`endif

endmodule
